// File: rtl/ddr_rd_gather_if.sv
// Read-path bundle between the DDR capture flops / command issue and the gather stage.
// Tag signals exist only when DDR_RD_GATHER_TAG_EN is defined.
interface ddr_rd_gather_if #(
   parameter int unsigned DQ_WIDTH  = 16
`ifdef DDR_RD_GATHER_TAG_EN
  ,parameter int unsigned TAG_WIDTH = 4
`endif
);
   logic                  rd_cmd;
   logic [3:0]            cas_lat;
   logic [DQ_WIDTH-1:0]   dq_rise;
   logic [DQ_WIDTH-1:0]   dq_fall;
   logic [2*DQ_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  rd_last;
   logic                  rd_err;
   logic                  busy;
`ifdef DDR_RD_GATHER_TAG_EN
   logic [TAG_WIDTH-1:0]  rd_tag_in;
   logic [TAG_WIDTH-1:0]  rd_tag;

   modport master (output rd_cmd, cas_lat, dq_rise, dq_fall, rd_tag_in,
                   input  rd_data, rd_valid, rd_last, rd_err, busy, rd_tag);
   modport slave  (input  rd_cmd, cas_lat, dq_rise, dq_fall, rd_tag_in,
                   output rd_data, rd_valid, rd_last, rd_err, busy, rd_tag);
`else
   modport master (output rd_cmd, cas_lat, dq_rise, dq_fall,
                   input  rd_data, rd_valid, rd_last, rd_err, busy);
   modport slave  (input  rd_cmd, cas_lat, dq_rise, dq_fall,
                   output rd_data, rd_valid, rd_last, rd_err, busy);
`endif
endinterface

// File: rtl/ddr_rd_gather.sv
// DDR read-data gather: times the read window from rd_cmd + CAS latency and frames
// captured rise/fall pairs into valid/last words. Optional read tag: DDR_RD_GATHER_TAG_EN.
module ddr_rd_gather #(
   parameter int unsigned DQ_WIDTH  = 16,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CL_MAX    = 7
`ifdef DDR_RD_GATHER_TAG_EN
  ,parameter int unsigned TAG_WIDTH = 4
`endif
) (
   input logic             clk,
   input logic             rst_n,
   ddr_rd_gather_if.slave  bus
);
   localparam int unsigned N     = BURST_LEN / 2;
   localparam int unsigned CNT_W = ($clog2(N + 1) < 2) ? 2 : $clog2(N + 1);
   localparam int unsigned IDX_W = (CL_MAX > 1) ? $clog2(CL_MAX) : 1;
   localparam int unsigned DW    = 2 * DQ_WIDTH;

   logic [CL_MAX-1:0] dl_q, dl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DW-1:0]     data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic [IDX_W-1:0]  tap_idx;
   logic              tap;

   // Clamp CAS latency to 1..CL_MAX and select the matching delay-line stage.
   always_comb begin
      tap_idx = '0;
      if (bus.cas_lat == 4'd0)
         tap_idx = '0;
      else if (32'(bus.cas_lat) > CL_MAX)
         tap_idx = IDX_W'(CL_MAX - 1);
      else
         tap_idx = IDX_W'(bus.cas_lat - 4'd1);
      tap = dl_q[tap_idx];
   end

   // Window tracking: a tap reloads the beat counter; a tap arriving while
   // the counter is still >1 truncates the older burst and flags an overlap.
   always_comb begin
      dl_d    = CL_MAX'({dl_q, bus.rd_cmd});
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      err_d   = 1'b0;
      if (tap) begin
         cnt_d   = CNT_W'(N);
         valid_d = 1'b1;
         last_d  = (N == 1);
         err_d   = (cnt_q > CNT_W'(1));
      end else begin
         if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
         valid_d = (cnt_q > CNT_W'(1));
         last_d  = (N > 1) && (cnt_q == CNT_W'(2));
      end
      if (valid_d)
         data_d = {bus.dq_fall, bus.dq_rise};
      busy_d = (|dl_d) || (cnt_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         dl_q    <= dl_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.rd_data  = data_q;
   assign bus.rd_valid = valid_q;
   assign bus.rd_last  = last_q;
   assign bus.rd_err   = err_q;
   assign bus.busy     = busy_q;

`ifdef DDR_RD_GATHER_TAG_EN
   logic [TAG_WIDTH-1:0] tag_dl_q [CL_MAX];
   logic [TAG_WIDTH-1:0] tag_dl_d [CL_MAX];
   logic [TAG_WIDTH-1:0] tag_q, tag_d;

   // Tag shifts alongside the command; captured at the tap and held for the burst.
   always_comb begin
      tag_dl_d[0] = bus.rd_tag_in;
      for (int i = 1; i < int'(CL_MAX); i++)
         tag_dl_d[i] = tag_dl_q[i-1];
      tag_d = tap ? tag_dl_q[tap_idx] : tag_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(CL_MAX); i++)
            tag_dl_q[i] <= '0;
         tag_q <= '0;
      end else begin
         for (int i = 0; i < int'(CL_MAX); i++)
            tag_dl_q[i] <= tag_dl_d[i];
         tag_q <= tag_d;
      end
   end

   assign bus.rd_tag = tag_q;
`endif
endmodule
